// File: rtl/bulk_sequencer_if.sv
// Bulk-port bundle between the burst sequencer and its client/controller.
// The sequencer is the master: it drives the request, address and strobe side.
interface bulk_sequencer_if;
    logic        START;
    logic [25:0] START_ADDR;
    logic [7:0]  LENGTH;
    logic        WRITE;
    logic        ABORT;
    logic [25:0] ADDRESS_BULK;
    logic        WE_BULK;
    logic        REQUEST_ACCESS_BULK;
    logic        GRANT_ACCESS_BULK;
    logic        REQUEST_ALIGN_BULK;
    logic        GRANT_ALIGN_BULK;
    logic        DATA_STROBE;
    logic [7:0]  WORD_INDEX;
    logic        BUSY;
    logic        DONE;
    logic        ABORTED;

    modport master (
        input  START, START_ADDR, LENGTH, WRITE, ABORT,
        input  GRANT_ACCESS_BULK, GRANT_ALIGN_BULK,
        output ADDRESS_BULK, WE_BULK, REQUEST_ACCESS_BULK, REQUEST_ALIGN_BULK,
        output DATA_STROBE, WORD_INDEX, BUSY, DONE, ABORTED
    );

    modport slave (
        output START, START_ADDR, LENGTH, WRITE, ABORT,
        output GRANT_ACCESS_BULK, GRANT_ALIGN_BULK,
        input  ADDRESS_BULK, WE_BULK, REQUEST_ACCESS_BULK, REQUEST_ALIGN_BULK,
        input  DATA_STROBE, WORD_INDEX, BUSY, DONE, ABORTED
    );
endinterface

// File: rtl/bulk_sequencer.sv
// Burst front-end for the DDR bulk port: walks a start address word by word,
// re-aligning the page whenever the column wraps past 12'hFFF.
module bulk_sequencer (
    input  logic             CLK,
    input  logic             RST,
    bulk_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ALIGN, ACCESS, DRAIN} state_t;

    state_t      state;
    logic [25:0] addr;
    logic        we;
    logic        req_access;
    logic        req_align;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        blank;
    logic [8:0]  remaining;
    logic [7:0]  index;
    logic        strobe;
    logic        last_word;
    logic        page_end;

    // A late grant in DRAIN is still a real word on the data path.
    assign strobe    = bus.GRANT_ACCESS_BULK && (state == ACCESS || state == DRAIN);
    assign last_word = (remaining == 9'd1);
    assign page_end  = (addr[11:0] == 12'hFFF);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            addr       <= 26'd0;
            we         <= 1'b0;
            req_access <= 1'b0;
            req_align  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            blank      <= 1'b0;
            remaining  <= 9'd0;
            index      <= 8'd0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (strobe) begin
                index     <= index + 8'd1;
                remaining <= remaining - 9'd1;
                addr      <= addr + 26'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        addr      <= bus.START_ADDR;
                        we        <= bus.WRITE;
                        remaining <= (bus.LENGTH == 8'd0) ? 9'd256 : {1'b0, bus.LENGTH};
                        index     <= 8'd0;
                        blank     <= 1'b1;
                        req_align <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ALIGN;
                    end
                end
                ALIGN: begin
                    // First ALIGN cycle: the align grant is a registered compare
                    // that may still describe the previous page.
                    if (bus.ABORT) begin
                        req_align <= 1'b0;
                        state     <= DRAIN;
                    end else if (blank) begin
                        blank <= 1'b0;
                    end else if (bus.GRANT_ALIGN_BULK) begin
                        req_access <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.GRANT_ACCESS_BULK && last_word) begin
                        req_align  <= 1'b0;
                        req_access <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else if (bus.ABORT) begin
                        req_align  <= 1'b0;
                        req_access <= 1'b0;
                        state      <= DRAIN;
                    end else if (bus.GRANT_ACCESS_BULK && page_end) begin
                        req_access <= 1'b0;
                        blank      <= 1'b1;
                        state      <= ALIGN;
                    end
                end
                DRAIN: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    aborted <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ADDRESS_BULK        = addr;
    assign bus.WE_BULK             = we;
    assign bus.REQUEST_ACCESS_BULK = req_access;
    assign bus.REQUEST_ALIGN_BULK  = req_align;
    assign bus.DATA_STROBE         = strobe;
    assign bus.WORD_INDEX          = strobe ? index : 8'd0;
    assign bus.BUSY                = busy;
    assign bus.DONE                = done;
    assign bus.ABORTED             = aborted;
endmodule
